crc16_frame_checker: RTL and testbench

CRC16_FRAME_CHECKER -- requirements
Module: crc16_frame_checker

---
 rtl/crc16_frame_checker.sv | 132 +++++++++++++
 tb/tb_crc16_frame_checker.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/crc16_frame_checker.sv
// Byte-parallel CRC-16 frame checker (MSB-first, no reflection, no final XOR).
// Tracks frame boundaries from sof/eof and reports good, corrupt or bad-length frames.
module crc16_frame_checker #(
   parameter logic [15:0] POLY    = 16'h8005,
   parameter logic [15:0] INIT    = 16'h0000,
   parameter int          MAX_LEN = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  data,
   input  logic        data_valid,
   input  logic        sof,
   input  logic        eof,
   output logic [15:0] crc_calc,
   output logic [10:0] byte_cnt,
   output logic        busy,
   output logic        frame_done,
   output logic        crc_ok,
   output logic        crc_err,
   output logic        len_err
);

   typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;

   localparam logic [10:0] MAX_CNT = 11'(MAX_LEN);

   state_t      state_q, state_d;
   logic [15:0] crc_q, crc_d;
   logic [10:0] cnt_q, cnt_d;
   logic        done_q, done_d;
   logic        ok_q, ok_d;
   logic        cerr_q, cerr_d;
   logic        lerr_q, lerr_d;
   logic [15:0] crc_upd, crc_new;
   logic [10:0] cnt_inc;

   function automatic logic [15:0] crc_update(input logic [15:0] c, input logic [7:0] d);
      logic [15:0] r;
      r = c;
      for (int i = 7; i >= 0; i--) begin
         r = (r[15] ^ d[i]) ? ({r[14:0], 1'b0} ^ POLY) : {r[14:0], 1'b0};
      end
      return r;
   endfunction

   function automatic logic [10:0] sat_inc(input logic [10:0] c);
      return (&c) ? c : c + 11'd1;
   endfunction

   always_comb begin
      state_d = state_q;
      crc_d   = crc_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      ok_d    = 1'b0;
      cerr_d  = 1'b0;
      lerr_d  = 1'b0;
      crc_upd = crc_update(crc_q, data);
      crc_new = crc_update(INIT, data);
      cnt_inc = sat_inc(cnt_q);
      case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (data_valid && sof) begin
               crc_d   = crc_new;
               cnt_d   = 11'd1;
               state_d = eof ? DONE : RECV;
               // A one-byte frame is always too short.
               done_d  = eof;
               lerr_d  = eof;
            end
         end
         RECV: begin
            if (data_valid) begin
               if (sof) begin
                  // Abort: report the dropped frame and restart on this byte.
                  crc_d   = crc_new;
                  cnt_d   = 11'd1;
                  state_d = eof ? DONE : RECV;
                  done_d  = 1'b1;
                  lerr_d  = 1'b1;
               end else if (cnt_q >= MAX_CNT) begin
                  done_d  = 1'b1;
                  lerr_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  crc_d = crc_upd;
                  cnt_d = cnt_inc;
                  if (eof) begin
                     state_d = DONE;
                     done_d  = 1'b1;
                     if (cnt_inc < 11'd3)       lerr_d = 1'b1;
                     else if (crc_upd == 16'h0) ok_d   = 1'b1;
                     else                       cerr_d = 1'b1;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Result pulses are registered so they appear in the DONE cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         crc_q   <= INIT;
         cnt_q   <= 11'd0;
         done_q  <= 1'b0;
         ok_q    <= 1'b0;
         cerr_q  <= 1'b0;
         lerr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         crc_q   <= crc_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         ok_q    <= ok_d;
         cerr_q  <= cerr_d;
         lerr_q  <= lerr_d;
      end
   end

   assign crc_calc   = crc_q;
   assign byte_cnt   = cnt_q;
   assign busy       = (state_q == RECV);
   assign frame_done = done_q;
   assign crc_ok     = ok_q;
   assign crc_err    = cerr_q;
   assign len_err    = lerr_q;

endmodule

// File: tb/tb_crc16_frame_checker.sv
// Bench for crc16_frame_checker: frame-list model with polynomial-division CRC,
// per-cycle comparison plus hand-computed literal expectations.
module tb_crc16_frame_checker;

   localparam logic [15:0] POLY    = 16'h8005;
   localparam logic [15:0] INIT    = 16'h0000;
   localparam int          MAX_LEN = 1024;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [7:0]  data = 8'h00;
   logic        data_valid = 1'b0;
   logic        sof = 1'b0;
   logic        eof = 1'b0;
   logic [15:0] crc_calc;
   logic [10:0] byte_cnt;
   logic        busy, frame_done, crc_ok, crc_err, len_err;

   int n_tests = 0;
   int n_fail  = 0;
   logic chk_en = 1'b0;

   // Model: bytes of the current/last frame, whether a frame is open, expected pulses.
   logic [7:0] m_bytes[$];
   logic       m_open = 1'b0;
   logic       e_done = 1'b0, e_ok = 1'b0, e_cerr = 1'b0, e_lerr = 1'b0;

   logic [7:0] good [11] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36,
                             8'h37, 8'h38, 8'h39, 8'hFE, 8'hE8};

   crc16_frame_checker #(.POLY(POLY), .INIT(INIT), .MAX_LEN(MAX_LEN)) dut (
      .clk(clk), .rst(rst), .data(data), .data_valid(data_valid), .sof(sof), .eof(eof),
      .crc_calc(crc_calc), .byte_cnt(byte_cnt), .busy(busy), .frame_done(frame_done),
      .crc_ok(crc_ok), .crc_err(crc_err), .len_err(len_err)
   );

   always #5 clk = ~clk;

   // CRC with zero INIT = remainder of M(x)*x^16 divided by the generator.
   function automatic logic [15:0] crc_div();
      logic [16:0] rem;
      rem = 17'h0;
      foreach (m_bytes[k]) begin
         for (int b = 7; b >= 0; b--) begin
            rem = {rem[15:0], m_bytes[k][b]};
            if (rem[16]) rem = rem ^ {1'b1, POLY};
         end
      end
      for (int z = 0; z < 16; z++) begin
         rem = {rem[15:0], 1'b0};
         if (rem[16]) rem = rem ^ {1'b1, POLY};
      end
      return rem[15:0];
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic close_frame();
      m_open = 1'b0;
      e_done = 1'b1;
      if (m_bytes.size() < 3)     e_lerr = 1'b1;
      else if (crc_div() == 16'h0) e_ok = 1'b1;
      else                         e_cerr = 1'b1;
   endtask

   initial begin
      forever begin
         @(posedge clk or posedge rst);
         e_done = 1'b0; e_ok = 1'b0; e_cerr = 1'b0; e_lerr = 1'b0;
         if (rst) begin
            m_bytes.delete();
            m_open = 1'b0;
         end else if (data_valid) begin
            if (sof) begin
               if (m_open) begin
                  e_done = 1'b1;
                  e_lerr = 1'b1;
               end
               m_bytes.delete();
               m_bytes.push_back(data);
               m_open = 1'b1;
               if (eof) close_frame();
            end else if (m_open) begin
               if (m_bytes.size() >= MAX_LEN) begin
                  e_done = 1'b1;
                  e_lerr = 1'b1;
                  m_open = 1'b0;
               end else begin
                  m_bytes.push_back(data);
                  if (eof) close_frame();
               end
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (chk_en) begin
            check("crc_calc",   crc_calc,   (m_bytes.size() == 0) ? INIT : crc_div());
            check("byte_cnt",   byte_cnt,   m_bytes.size());
            check("busy",       busy,       m_open);
            check("frame_done", frame_done, e_done);
            check("crc_ok",     crc_ok,     e_ok);
            check("crc_err",    crc_err,    e_cerr);
            check("len_err",    len_err,    e_lerr);
         end
      end
   end

   task automatic byte_in(input logic [7:0] d, input logic s, input logic e);
      data = d; data_valid = 1'b1; sof = s; eof = e;
      @(posedge clk); #1;
      data_valid = 1'b0; sof = 1'b0; eof = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic send_frame(input logic bad_last);
      for (int i = 0; i < 11; i++) begin
         byte_in((i == 10 && bad_last) ? 8'hE9 : good[i], i == 0, i == 10);
      end
   endtask

   initial begin
      for (int i = 0; i < 9; i++) m_bytes.push_back(good[i]);
      check("model_check_value", crc_div(), 16'hFEE8);
      m_bytes.delete();

      #1 rst = 1'b1;
      idle(2);
      rst = 1'b0;
      chk_en = 1'b1;
      check("reset_crc", crc_calc, 16'h0000);
      check("reset_cnt", byte_cnt, 11'd0);
      check("reset_flags", {busy, frame_done, crc_ok, crc_err, len_err}, 5'b0);

      // Valid bytes without sof are ignored while idle.
      byte_in(8'h55, 1'b0, 1'b0);
      check("idle_ignore_cnt", byte_cnt, 11'd0);

      // Good frame.
      for (int i = 0; i < 9; i++) byte_in(good[i], i == 0, 1'b0);
      check("good_crc_after_39", crc_calc, 16'hFEE8);
      byte_in(8'hFE, 1'b0, 1'b0);
      byte_in(8'hE8, 1'b0, 1'b1);
      check("good_crc_final", crc_calc, 16'h0000);
      check("good_crc_ok", crc_ok, 1'b1);
      check("good_done", frame_done, 1'b1);
      check("good_cnt", byte_cnt, 11'd11);
      idle(1);
      check("good_pulse_one_cycle", frame_done, 1'b0);
      check("good_hold_cnt", byte_cnt, 11'd11);

      // Corrupt frame; a non-sof byte in the DONE cycle is ignored.
      idle(1);
      send_frame(1'b1);
      check("bad_crc_err", crc_err, 1'b1);
      check("bad_crc_ok", crc_ok, 1'b0);
      check("bad_crc_val", crc_calc, 16'h8005);
      byte_in(8'h77, 1'b0, 1'b0);
      check("done_ignore_crc", crc_calc, 16'h8005);
      check("done_ignore_cnt", byte_cnt, 11'd11);

      // Short frame: one byte with sof and eof.
      idle(2);
      byte_in(8'h00, 1'b1, 1'b1);
      check("short_len_err", len_err, 1'b1);
      check("short_no_ok", {crc_ok, crc_err}, 2'b00);
      check("short_cnt", byte_cnt, 11'd1);

      // Abort with gaps, then a good frame on the restart.
      idle(2);
      byte_in(8'h31, 1'b1, 1'b0);
      idle(2);
      byte_in(8'h32, 1'b0, 1'b0);
      idle(1);
      byte_in(8'h31, 1'b1, 1'b0);
      check("abort_len_err", len_err, 1'b1);
      check("abort_done", frame_done, 1'b1);
      check("abort_busy", busy, 1'b1);
      check("abort_cnt", byte_cnt, 11'd1);
      for (int i = 1; i < 11; i++) byte_in(good[i], 1'b0, i == 10);
      check("abort_then_ok", crc_ok, 1'b1);

      // Back-to-back frames, second sof in the DONE cycle.
      idle(2);
      send_frame(1'b0);
      check("b2b_first_ok", crc_ok, 1'b1);
      send_frame(1'b0);
      check("b2b_second_ok", crc_ok, 1'b1);
      check("b2b_second_cnt", byte_cnt, 11'd11);

      // Async reset mid-frame, between clock edges.
      idle(2);
      for (int i = 0; i < 5; i++) byte_in(good[i], i == 0, 1'b0);
      #2 rst = 1'b1;
      #1;
      check("async_rst_crc", crc_calc, 16'h0000);
      check("async_rst_cnt", byte_cnt, 11'd0);
      check("async_rst_flags", {busy, frame_done, crc_ok, crc_err, len_err}, 5'b0);
      @(posedge clk); #3 rst = 1'b0;
      idle(1);
      send_frame(1'b0);
      check("after_rst_ok", crc_ok, 1'b1);

      // Overlong frame: byte 1025 is rejected without being counted.
      idle(2);
      byte_in(8'h00, 1'b1, 1'b0);
      for (int i = 1; i < MAX_LEN; i++) byte_in(8'(i), 1'b0, 1'b0);
      check("long_cnt_max", byte_cnt, 11'd1024);
      check("long_busy", busy, 1'b1);
      byte_in(8'hAA, 1'b0, 1'b1);
      check("long_len_err", len_err, 1'b1);
      check("long_done", frame_done, 1'b1);
      check("long_not_busy", busy, 1'b0);
      check("long_cnt_held", byte_cnt, 11'd1024);
      check("long_no_ok", {crc_ok, crc_err}, 2'b00);
      idle(3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
